// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// First-word-fall-through storage with occupancy level, full/empty decodes,
// a sticky overflow flag and a level-threshold interrupt. The receiver cannot
// be stalled, so a byte arriving while full (with no pop) is dropped and
// recorded in the overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  input  logic             clr_overflow,
  input  logic             flush,
  input  logic [LVL_W-1:0] irq_thresh,
  output logic             irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;

  logic pop_ok;
  logic push;
  logic drop;
  logic wr_mem;

  // Status decodes of the registered state.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    level    = level_q;
    overflow = overflow_q;
    rd_data  = empty ? 8'h00 : mem_q[rptr_q];
    irq      = (irq_thresh != '0) && (level_q >= irq_thresh);
  end

  // Push/pop/drop qualification; a pop frees the slot the push needs when full.
  always_comb begin
    pop_ok = rd_en && !empty;
    push   = in_valid && (!full || pop_ok);
    drop   = in_valid && full && !pop_ok;
    wr_mem = push && !flush;
  end

  // Next-state for pointers, level and the sticky overflow flag.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (flush) begin
      // Flush discards any coincident push/pop, including the drop case.
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok) rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop_ok) level_d = level_q + LVL_W'(1);
      else if (pop_ok && !push) level_d = level_q - LVL_W'(1);
    end

    // Set has priority over clear.
    if (clr_overflow) overflow_d = 1'b0;
    if (drop && !flush) overflow_d = 1'b1;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_mem) mem_q[wptr_q] <= in_data;
  end

endmodule
